reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 99 +++++++++
 tb/tb_reg_write_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester write arbiter for a shared 32x32 register bank: round-robin on ties, one-cycle write latency.
// Optional feature: define REG_ZERO_DROP_EN to accept but suppress writes to register index 0.
module reg_write_arbiter (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        wr_stall,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        grant_id
);

    // Handshake: a requester transfers on a rising edge where its valid and ready are both 1;
    // ready never depends on addr/data, and at most one ready is high per cycle.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

    pri_e        pri_q, pri_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        grant_q, grant_d;
    logic        xfer0, xfer1;
    logic [4:0]  win_addr;
    logic        do_write;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (clr && !wr_stall) begin
            req0_ready = req0_valid && (!req1_valid || pri_q == PRI0);
            req1_ready = req1_valid && (!req0_valid || pri_q == PRI1);
        end
    end

    assign xfer0    = req0_valid && req0_ready;
    assign xfer1    = req1_valid && req1_ready;
    assign win_addr = xfer1 ? req1_addr : req0_addr;

    always_comb begin
        do_write = xfer0 || xfer1;
`ifdef REG_ZERO_DROP_EN
        // The handshake and priority update still happen; only the bank write is dropped.
        if (win_addr == 5'd0) begin
            do_write = 1'b0;
        end
`endif
    end

    always_comb begin
        pri_d     = pri_q;
        wr_en_d   = do_write;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        grant_d   = grant_q;
        if (xfer0) begin
            pri_d = PRI1;
        end else if (xfer1) begin
            pri_d = PRI0;
        end
        if (do_write) begin
            wr_addr_d = win_addr;
            wr_data_d = xfer1 ? req1_data : req0_data;
            grant_d   = xfer1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pri_q     <= PRI0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
            grant_q   <= 1'b0;
        end else begin
            pri_q     <= pri_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            grant_q   <= grant_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomised and directed bench for reg_write_arbiter against a behavioural arbitration model.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, wr_stall = 1'b0;
    logic [4:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, wr_en, grant_id;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who wins a tie, and what the bank port should show.
    int          m_winner = 0;
    logic        m_en = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_grant = 1'b0;
    logic [37:0] exp_q[$];

    reg_write_arbiter dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("wr_en", wr_en, m_en);
        check_eq("wr_addr", wr_addr, m_addr);
        check_eq("wr_data", wr_data, m_data);
        check_eq("grant_id", grant_id, m_grant);
    endtask

    // One clock cycle: drive at the falling edge, check readies, then check the write port after the edge.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic st);
        logic r0, r1;
        @(negedge clk);
        clr = 1'b1;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        wr_stall = st;
        r0 = 1'b0;
        r1 = 1'b0;
        if (!st) begin
            if (v0 && v1) begin
                r0 = (m_winner == 0);
                r1 = (m_winner == 1);
            end else begin
                r0 = v0;
                r1 = v1;
            end
        end
        #1;
        check_eq("req0_ready", req0_ready, r0);
        check_eq("req1_ready", req1_ready, r1);
        @(posedge clk);
        if (r0) begin
            exp_q.push_back({1'b0, a0, d0});
            m_winner = 1;
        end else if (r1) begin
            exp_q.push_back({1'b1, a1, d1});
            m_winner = 0;
        end
        m_en = 1'b0;
        if (exp_q.size() > 0) begin
            logic [37:0] w;
            w = exp_q.pop_front();
`ifdef REG_ZERO_DROP_EN
            if (w[36:32] != 5'd0) begin
                m_en = 1'b1;
                {m_grant, m_addr, m_data} = w;
            end
`else
            m_en = 1'b1;
            {m_grant, m_addr, m_data} = w;
`endif
        end
        #1;
        check_outputs();
    endtask

    // Asserts clr shortly after a rising edge and leaves it low; the next step releases it.
    task automatic reset_now();
        #1;
        clr = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wr_stall = 1'b0;
        m_winner = 0;
        m_en = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_grant = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        check_eq("rst_req0_ready", req0_ready, 1'b0);
        check_eq("rst_req1_ready", req1_ready, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        reset_now();
        @(posedge clk);
        #1;
        check_outputs();

        // Contention right after reset: alternating grants starting with requester 0.
        for (int i = 0; i < 6; i++)
            step(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, 1'b0);

        // Mid-run reset while a write is on the port, then both valid must go to requester 0.
        check_eq("pre_reset_wr_en", wr_en, 1'b1);
        reset_now();
        step(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd10, 32'h0000_00AA, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Single streamer on requester 1: back-to-back writes in order.
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'd1, 32'h0, 1'b1, 5'd4, 32'hA0 + i, 1'b0);

        // Stall with both valid: nothing granted, priority held through it.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b1);
        step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        // Zero address write from requester 0.
        step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd2, 32'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 99) == 0) begin
                reset_now();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
